data_mem_unit: RTL and testbench
================================

Name: data_mem_unit

Overview:
- Parametrised successor to the single-port data memory used by the datapath's memory stage.
- Replaces the raw block-RAM style port (enable, per-lane write strobes, word data) with a request/response handshake.
- Adds sized loads and stores (byte, half, word), sign or zero extension, configurable read latency and error detection for misaligned or out-of-range accesses.
- Sits between the CPU memory stage and an internal byte-enabled synchronous RAM.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; valid word index is 0..DEPTH_WORDS-1.
- RD_LAT, 1, load latency in cycles from accept to response; legal range 1..3.
- ADDR_W, 32, byte-address width.

Ports:
- clka  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address; little-endian.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  out  1  access rejected.

Behaviour:
- Reset (asynchronous): FSM goes to IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=0 while rst is high, then 1 in the first cycle after deassertion. RAM contents are not cleared.
- FSM states:
  - IDLE: req_ready=1. A request is accepted in cycle T when req_valid & req_ready.
  - WAIT: req_ready=0. A counter counts RD_LAT-1 cycles (loads with RD_LAT>1 only).
  - RESP: one cycle; rsp_valid=1 and req_ready=1. The unit can accept a new request in the same cycle, so back-to-back operation is possible.
- Error check at accept. rsp_err=1 when any of the following holds:
  - size=11;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - addr[ADDR_W-1:2] >= DEPTH_WORDS.
- Error response: no RAM access (no write, no read); rsp_valid at T+1 with rsp_err=1 and rsp_rdata=0.
- Store: byte strobes come from size and addr[1:0] (byte: 1<<a; half: 0011 or 1100; word: 1111). wdata is replicated across lanes. The write commits on the edge that ends T. rsp_valid at T+1 with rsp_err=0 and rsp_rdata=0.
- Load: the RAM is read in T. rsp_valid at T+RD_LAT. The selected lane is shifted down and extended according to req_unsigned (size, offset and unsigned flag are captured at accept). rsp_err=0.
- rsp_valid is high for exactly one cycle per accepted request. There is no response backpressure.
- Outputs hold their last values after rsp_valid drops, except that rsp_valid itself returns to 0.
- Store followed by a load to the same address, back-to-back: the load returns the new data, because the write committed before the read cycle.
- rst asserted mid-operation: the pending request is dropped and no rsp_valid is produced. A store already committed stays committed.
- req_valid while req_ready=0 is ignored; the requester must hold it.
- Address wrap-around is not supported; out-of-range accesses are reported as errors.

Decomposition:
- Shared package:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state encoding IDLE, WAIT, RESP;
  - a function that maps size and offset to the 4-bit byte strobe;
  - a function that extracts and extends a lane.
- Sub-module mem_array_be: synchronous RAM of DEPTH_WORDS x 32 with 4 byte write-enables, followed by RD_LAT-1 output register stages.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately; req_ready=1 in the first cycle after release.
- sw 0xDEADBEEF @0x10, then lw @0x10 (RD_LAT=1) -> store rsp_valid at T+1 with err=0; load rsp_rdata=0xDEADBEEF at T'+1.
- sb 0x80 @0x13, then lb @0x13 -> 0xFFFFFF80; lbu @0x13 -> 0x00000080; lw @0x10 -> 0x80ADBEEF; lhu @0x12 -> 0x000080AD.
- lh @0x11, sw @0x12, req_size=11, and lw @(DEPTH_WORDS*4) -> each gives rsp_err=1 and rdata=0; a later lw @0x10 is unchanged.
- RD_LAT=3, req_valid held high with 4 alternating sw/lw -> each load responds at T+3; req_ready=0 during WAIT; one rsp_valid per request.
- RD_LAT=3: lw accepted, rst pulsed at T+1 -> no rsp_valid ever appears for that load; the next request after reset completes normally.

Source files
------------

// File: rtl/data_mem_unit_pkg.sv
// data_mem_unit_pkg: size encodings, FSM states and lane helpers shared by the data memory unit.
package data_mem_unit_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  function automatic logic [3:0] strobe(input logic [1:0] size, input logic [1:0] off);
    return size == SZ_BYTE ? 4'b0001 << off :
           size == SZ_HALF ? (off[1] ? 4'b1100 : 4'b0011) :
           size == SZ_WORD ? 4'b1111 : 4'b0000;
  endfunction
  function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] size,
                                         input logic [1:0] off, input logic uns);
    logic [31:0] s;
    s = word >> {off, 3'b000};
    return size == SZ_BYTE ? {{24{~uns & s[7]}}, s[7:0]} :
           size == SZ_HALF ? {{16{~uns & s[15]}}, s[15:0]} : s;
  endfunction
endpackage

// File: rtl/data_mem_unit_mem_array_be.sv
// mem_array_be: byte-enabled synchronous RAM followed by RD_LAT-1 output register stages.
module mem_array_be #(
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LAT = 1,
  parameter int IW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [3:0]    be,
  input  logic [IW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] pipe [RD_LAT];
  always_ff @(posedge clk) begin
    if (re) pipe[0] <= mem[idx];
    for (int i = 0; i < 4; i++) if (we && be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign rdata = pipe[RD_LAT-1];
endmodule

// File: rtl/data_mem_unit.sv
// data_mem_unit: request/response data memory with sized, extended loads/stores and access-error detection.
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 32
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int IW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  state_t state, nxt;
  logic accept, err, we, re, c_uns, c_we, c_err, hold_err;
  logic [1:0] cnt, c_size, c_off;
  logic [3:0] be;
  logic [31:0] ram_q, cur, hold_rdata, wrep;
  assign accept = req_valid & req_ready;
  assign err = req_size == SZ_ILL || (req_size == SZ_HALF && req_addr[0]) ||
               (req_size == SZ_WORD && req_addr[1:0] != 2'b00) ||
               (req_addr >> 2) >= ADDR_W'(DEPTH_WORDS);
  assign we = accept & req_we & ~err;
  assign re = accept & ~req_we & ~err;
  assign be = strobe(req_size, req_addr[1:0]);
  assign wrep = req_size == SZ_BYTE ? {4{req_wdata[7:0]}} :
                req_size == SZ_HALF ? {2{req_wdata[15:0]}} : req_wdata;
  assign cur = c_we | c_err ? 32'd0 : extend(ram_q, c_size, c_off, c_uns);
  mem_array_be #(.DEPTH_WORDS(DEPTH_WORDS), .RD_LAT(RD_LAT), .IW(IW)) u_mem (
    .clk(clka), .we(we), .re(re), .be(be), .idx(req_addr[IW+1:2]), .wdata(wrep), .rdata(ram_q)
  );
  always_ff @(posedge clka or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // only error-free loads with extra latency pass through WAIT
  always_comb
    nxt = state == WAIT ? (cnt == 2'(RD_LAT - 2) ? RESP : WAIT) :
          !accept ? IDLE : (!req_we && !err && RD_LAT > 1) ? WAIT : RESP;
  always_comb begin
    req_ready = !rst && state != WAIT;
    rsp_valid = state == RESP;
    rsp_rdata = rsp_valid ? cur : hold_rdata;
    rsp_err = rsp_valid ? c_err : hold_err;
  end
  always_ff @(posedge clka or posedge rst)
    if (rst) begin
      cnt <= 2'd0;
      c_size <= SZ_BYTE;
      c_off <= 2'd0;
      c_uns <= 1'b0;
      c_we <= 1'b0;
      c_err <= 1'b0;
      hold_rdata <= 32'd0;
      hold_err <= 1'b0;
    end else begin
      if (accept) begin
        c_size <= req_size;
        c_off <= req_addr[1:0];
        c_uns <= req_unsigned;
        c_we <= req_we;
        c_err <= err;
      end
      cnt <= state == WAIT ? cnt + 2'd1 : 2'd0;
      if (state == RESP) begin
        hold_rdata <= cur;
        hold_err <= c_err;
      end
    end
endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: directed scoreboard bench for data_mem_unit at read latencies 1 and 3.
module tb_data_mem_unit;
  typedef struct { logic [31:0] d; logic e; int t; int l; } exp_t;
  logic clka = 0, rst = 1;
  logic v1 = 0, we1 = 0, un1 = 0, rdy1, rv1, er1;
  logic v3 = 0, we3 = 0, un3 = 0, rdy3, rv3, er3;
  logic [1:0] sz1 = 0, sz3 = 0;
  logic [31:0] ad1 = 0, wd1 = 0, rd1, ad3 = 0, wd3 = 0, rd3;
  int total = 0, bad = 0, cyc = 0;
  exp_t q1[$], q3[$];
  exp_t m1, m3;

  always #5 clka = ~clka;
  always @(posedge clka) cyc <= cyc + 1;

  data_mem_unit #(.DEPTH_WORDS(1024), .RD_LAT(1), .ADDR_W(32)) u1 (
    .clka(clka), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_we(we1), .req_size(sz1),
    .req_unsigned(un1), .req_addr(ad1), .req_wdata(wd1), .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(er1));
  data_mem_unit #(.DEPTH_WORDS(1024), .RD_LAT(3), .ADDR_W(32)) u3 (
    .clka(clka), .rst(rst), .req_valid(v3), .req_ready(rdy3), .req_we(we3), .req_size(sz3),
    .req_unsigned(un3), .req_addr(ad3), .req_wdata(wd3), .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(er3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clka) if (rv1) begin
    if (q1.size() == 0) begin
      total++; bad++;
      $display("FAIL u1_spurious_rsp: got rsp_valid=1 want no response at cycle %0d", cyc);
    end else begin
      m1 = q1.pop_front();
      chk("u1_rdata", rd1, m1.d);
      chk("u1_err", 32'(er1), 32'(m1.e));
      chk("u1_latency", 32'(cyc), 32'(m1.t + m1.l));
    end
  end

  always @(negedge clka) if (rv3) begin
    if (q3.size() == 0) begin
      total++; bad++;
      $display("FAIL u3_spurious_rsp: got rsp_valid=1 want no response at cycle %0d", cyc);
    end else begin
      m3 = q3.pop_front();
      chk("u3_rdata", rd3, m3.d);
      chk("u3_err", 32'(er3), 32'(m3.e));
      chk("u3_latency", 32'(cyc), 32'(m3.t + m3.l));
    end
  end

  // Presents a request on the chosen instance, keeps valid high until accepted, queues the expectation.
  task automatic issue(input bit l3, input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] ex, input bit ee);
    exp_t x;
    int n;
    n = 0;
    @(negedge clka);
    if (l3) begin v3 = 1; we3 = we; sz3 = sz; un3 = uns; ad3 = a; wd3 = wd; end
    else begin v1 = 1; we1 = we; sz1 = sz; un1 = uns; ad1 = a; wd1 = wd; end
    while (!(l3 ? rdy3 : rdy1) && n < 20) begin
      @(negedge clka);
      n++;
    end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL accept_timeout: got req_ready=0 for %0d cycles want 1 (addr %h)", n, a);
      v1 = 0; v3 = 0;
      return;
    end
    x.d = ex; x.e = ee; x.t = cyc; x.l = (we || ee) ? 1 : (l3 ? 3 : 1);
    if (l3) q3.push_back(x);
    else q1.push_back(x);
    if (l3 && !we && !ee) begin
      @(negedge clka);
      chk("u3_ready_in_wait", 32'(rdy3), 32'd0);
    end
  endtask

  task automatic idle();
    @(negedge clka);
    v1 = 0;
    v3 = 0;
  endtask

  initial begin
    repeat (2) @(negedge clka);
    #1;
    chk("rst_valid", 32'(rv1), 32'd0);
    chk("rst_rdata", rd1, 32'd0);
    chk("rst_err", 32'(er1), 32'd0);
    chk("rst_ready", 32'(rdy1), 32'd0);
    rst = 0;
    #1;
    chk("ready_after_rst_u1", 32'(rdy1), 32'd1);
    chk("ready_after_rst_u3", 32'(rdy3), 32'd1);
    // latency 1: stores, sized loads and extension
    issue(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    issue(0, 1, 2'b00, 0, 32'h13, 32'h00000080, 32'h0, 0);
    issue(0, 0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFF80, 0);
    issue(0, 0, 2'b00, 1, 32'h13, 32'h0, 32'h00000080, 0);
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0);
    issue(0, 0, 2'b01, 1, 32'h12, 32'h0, 32'h000080AD, 0);
    issue(0, 0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFF80AD, 0);
    issue(0, 0, 2'b00, 0, 32'h10, 32'h0, 32'hFFFFFFEF, 0);
    issue(0, 0, 2'b00, 1, 32'h11, 32'h0, 32'h000000BE, 0);
    issue(0, 1, 2'b10, 0, 32'h20, 32'h0, 32'h0, 0);
    issue(0, 1, 2'b01, 0, 32'h22, 32'hBEEFCAFE, 32'h0, 0);
    issue(0, 0, 2'b10, 0, 32'h20, 32'h0, 32'hCAFE0000, 0);
    issue(0, 1, 2'b00, 0, 32'hFFF, 32'h0000005A, 32'h0, 0);
    issue(0, 0, 2'b00, 1, 32'hFFF, 32'h0, 32'h0000005A, 0);
    // rejected accesses
    issue(0, 0, 2'b01, 0, 32'h11, 32'h0, 32'h0, 1);
    issue(0, 1, 2'b10, 0, 32'h12, 32'h12345678, 32'h0, 1);
    issue(0, 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1);
    issue(0, 1, 2'b11, 0, 32'h10, 32'h11111111, 32'h0, 1);
    issue(0, 0, 2'b10, 0, 32'h1000, 32'h0, 32'h0, 1);
    issue(0, 1, 2'b10, 0, 32'h1000, 32'h99999999, 32'h0, 1);
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0);
    idle();
    repeat (2) @(negedge clka);
    #2 rst = 1;
    #1;
    chk("midrst_valid", 32'(rv1), 32'd0);
    chk("midrst_rdata", rd1, 32'd0);
    chk("midrst_err", 32'(er1), 32'd0);
    chk("midrst_ready", 32'(rdy1), 32'd0);
    @(negedge clka);
    rst = 0;
    #1;
    chk("ready_after_midrst", 32'(rdy1), 32'd1);
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0);
    idle();
    // latency 3: valid held across alternating stores and loads
    issue(1, 1, 2'b10, 0, 32'h40, 32'h11223344, 32'h0, 0);
    issue(1, 0, 2'b10, 0, 32'h40, 32'h0, 32'h11223344, 0);
    issue(1, 1, 2'b10, 0, 32'h44, 32'h55667788, 32'h0, 0);
    issue(1, 0, 2'b10, 0, 32'h44, 32'h0, 32'h55667788, 0);
    issue(1, 0, 2'b10, 0, 32'h41, 32'h0, 32'h0, 1);
    issue(1, 0, 2'b01, 0, 32'h46, 32'h0, 32'h00005566, 0);
    idle();
    repeat (4) @(negedge clka);
    // reset one cycle after a load is accepted drops its response
    issue(1, 0, 2'b10, 0, 32'h40, 32'h0, 32'h11223344, 0);
    #2 rst = 1;
    v3 = 0;
    q3.delete();
    @(negedge clka);
    rst = 0;
    repeat (6) @(negedge clka);
    issue(1, 0, 2'b10, 0, 32'h44, 32'h0, 32'h55667788, 0);
    idle();
    for (int i = 0; i < 10 && (q1.size() != 0 || q3.size() != 0); i++) @(negedge clka);
    chk("u1_all_responded", 32'(q1.size()), 32'd0);
    chk("u3_all_responded", 32'(q3.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
